// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage with valid/ready handshakes on
// both sides and a registered result. Base ops complete in one cycle. The
// MUL/MULH/MULHSU/MULHU ops and the optional divide ops share one iterative
// shift/add-subtract engine built around a 2*WIDTH accumulator.
// Optional feature: define ALU_MC_DIV_EN to build the divider
// (DIV/DIVU/REM/REMU). Without it, op codes 0x14-0x17 return 0 in one cycle.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_SLT  = 5'h02;
  localparam logic [4:0] OP_SLTU = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_AND  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_LUI  = 5'h0A;

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;      // {high/remainder, low/quotient}
  logic [WIDTH-1:0]     mag_q;    // multiplicand, or divisor magnitude
  logic [1:0]           sub_op;   // low two op bits of the running M op
  logic                 neg_q;    // negate product / quotient at the end

  logic                 accept;
  logic                 is_mul;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     base_result;
  logic                 a_sign, b_sign;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 mul_sa, mul_sb, mul_neg;
  logic [WIDTH-1:0]     mul_mag, mul_lo;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     done_result;

  // The unit takes a new op only from IDLE and only when any pending result
  // leaves on this same edge, so a result is never overwritten.
  assign o_ready = (state == S_IDLE) && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign is_mul  = (i_alu_op[4:3] == 2'b10) && !i_alu_op[2];
  assign shamt   = i_operand_b[SHAMT_W-1:0];

  // Single-cycle result for base ops; any unlisted code yields zero.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves it unassigned, so no latch is inferred.
    base_result = '0;
    case (i_alu_op)
      OP_ADD:  base_result = i_operand_a + i_operand_b;
      OP_SUB:  base_result = i_operand_a - i_operand_b;
      OP_SLT:  base_result = {{(WIDTH-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
      OP_SLTU: base_result = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
      OP_XOR:  base_result = i_operand_a ^ i_operand_b;
      OP_OR:   base_result = i_operand_a | i_operand_b;
      OP_AND:  base_result = i_operand_a & i_operand_b;
      OP_SLL:  base_result = i_operand_a << shamt;
      OP_SRL:  base_result = i_operand_a >> shamt;
      OP_SRA:  base_result = $signed(i_operand_a) >>> shamt;
      OP_LUI:  base_result = i_operand_b;
      default: base_result = '0;
    endcase
  end

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as unsigned.
  assign a_sign = i_operand_a[WIDTH-1];
  assign b_sign = i_operand_b[WIDTH-1];
  assign a_mag  = a_sign ? -i_operand_a : i_operand_a;
  assign b_mag  = b_sign ? -i_operand_b : i_operand_b;

  // Multiply setup: MULH signs both operands, MULHSU only a. MUL takes the
  // low half, which is the same for signed and unsigned, so it runs unsigned.
  assign mul_sa  = (i_alu_op[1:0] == 2'b01) || (i_alu_op[1:0] == 2'b10);
  assign mul_sb  = (i_alu_op[1:0] == 2'b01);
  assign mul_mag = mul_sa ? a_mag : i_operand_a;
  assign mul_lo  = mul_sb ? b_mag : i_operand_b;
  assign mul_neg = (mul_sa && a_sign) ^ (mul_sb && b_sign);

  // One radix-2 shift-add step: add the multiplicand when the LSB is set,
  // then shift the whole accumulator right, carry included.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  logic                 neg_r;    // negate remainder at the end
  logic                 is_div_q; // running op is a divide
  logic                 is_div;
  logic                 div_sgn;
  logic                 div_fast;
  logic                 b_zero, div_ovf;
  logic [WIDTH-1:0]     fast_result;
  logic [WIDTH:0]       div_trial, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     div_quo, div_rem;

  assign is_div   = (i_alu_op[4:3] == 2'b10) && i_alu_op[2];
  assign div_sgn  = !i_alu_op[0];
  assign b_zero   = (i_operand_b == '0);
  assign div_ovf  = div_sgn && (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_operand_b == '1);
  assign div_fast = b_zero || div_ovf;

  // Divide-by-zero and signed overflow bypass the engine entirely.
  always_comb begin
    fast_result = '0;
    if (b_zero) fast_result = i_alu_op[1] ? i_operand_a : '1;
    else        fast_result = i_alu_op[1] ? '0 : i_operand_a;
  end

  // One restoring step: shift in the next dividend bit and keep the trial
  // difference when it does not borrow. The trial needs WIDTH+1 bits because
  // 2*remainder+1 can exceed WIDTH bits for large unsigned divisors.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, mag_q};
  assign div_next  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign div_quo   = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign div_rem   = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  // Result selection when leaving the engine.
  always_comb begin
    done_result = '0;
    if (is_div_q) done_result = sub_op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    else          done_result = (sub_op == 2'b00) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
  end
`else
  // Result selection when leaving the engine.
  always_comb begin
    done_result = '0;
    done_result = (sub_op == 2'b00) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
  end
`endif

  // Control FSM, iterative engine and registered result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      o_valid    <= 1'b0;
      o_alu_data <= '0;
      count      <= '0;
      acc        <= '0;
      mag_q      <= '0;
      sub_op     <= '0;
      neg_q      <= 1'b0;
`ifdef ALU_MC_DIV_EN
      neg_r      <= 1'b0;
      is_div_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments let a later load in this block override the consume-clear below without ordering hazards.
      if (o_valid && i_ready) o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state    <= S_MUL;
              count    <= CNT_W'(WIDTH-1);
              acc      <= {{WIDTH{1'b0}}, mul_lo};
              mag_q    <= mul_mag;
              sub_op   <= i_alu_op[1:0];
              neg_q    <= mul_neg;
`ifdef ALU_MC_DIV_EN
              is_div_q <= 1'b0;
            end else if (is_div && div_fast) begin
              o_valid    <= 1'b1;
              o_alu_data <= fast_result;
            end else if (is_div) begin
              state    <= S_DIV;
              count    <= CNT_W'(WIDTH-1);
              acc      <= {{WIDTH{1'b0}}, div_sgn ? a_mag : i_operand_a};
              mag_q    <= div_sgn ? b_mag : i_operand_b;
              sub_op   <= i_alu_op[1:0];
              neg_q    <= div_sgn && (a_sign ^ b_sign);
              neg_r    <= div_sgn && a_sign;
              is_div_q <= 1'b1;
`endif
            end else begin
              o_valid    <= 1'b1;
              o_alu_data <= base_result;
            end
          end
        end
        S_MUL: begin
          if (count == '0) begin
            acc   <= neg_q ? -mul_next : mul_next;
            state <= S_DONE;
          end else begin
            acc   <= mul_next;
            count <= count - 1'b1;
          end
        end
`ifdef ALU_MC_DIV_EN
        S_DIV: begin
          if (count == '0) begin
            acc   <= {div_rem, div_quo};
            state <= S_DONE;
          end else begin
            acc   <= div_next;
            count <= count - 1'b1;
          end
        end
`endif
        S_DONE: begin
          o_valid    <= 1'b1;
          o_alu_data <= done_result;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=32). Randomized and directed stimulus checked
// against a behavioural model computed with plain integer arithmetic.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_SLT = 5'h02, OP_SLTU = 5'h03;
  localparam logic [4:0] OP_SRA = 5'h09;
  localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13;
  localparam logic [4:0] OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [4:0]   i_alu_op;
  logic [W-1:0] i_operand_a, i_operand_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_alu_data;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_op(i_alu_op), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_data(o_alu_data)
  );

  always #5 clk = ~clk;

  // Reference model: RISC-V RV32I/RV32M semantics from integer arithmetic.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [4:0] sh;
    ia = a; ib = b; sa = ia; sb = ib; ua = {32'b0, a}; ub = {32'b0, b}; sh = b[4:0];
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return (ia < ib) ? 32'd1 : 32'd0;
      5'h03: return (a < b) ? 32'd1 : 32'd0;
      5'h04: return a ^ b;
      5'h05: return a | b;
      5'h06: return a & b;
      5'h07: return a << sh;
      5'h08: return a >> sh;
      5'h09: return ia >>> sh;
      5'h0A: return b;
      5'h10: begin p = ua * ub; return p[31:0]; end
      5'h11: begin p = sa * sb; return p[63:32]; end
      5'h12: begin p = sa * longint'(ub); return p[63:32]; end
      5'h13: begin p = ua * ub; return p[63:32]; end
`ifdef ALU_MC_DIV_EN
      5'h14: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      5'h15: return (b == 0) ? '1 : a / b;
      5'h16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      5'h17: return (b == 0) ? a : a % b;
`endif
      default: return 0;
    endcase
  endfunction

  // Expected cycles from the accept edge until o_valid is seen.
  function automatic int exp_lat(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op >= 5'h10 && op <= 5'h13) return W + 1;
`ifdef ALU_MC_DIV_EN
    if (op >= 5'h14 && op <= 5'h17) begin
      if (b == 0) return 0;
      if ((op == 5'h14 || op == 5'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return W + 1;
    end
`endif
    return 0;
  endfunction

  // Issue one op with i_ready=1 and collect its result. lat is the number of
  // edges after the accept edge before o_valid is seen; -1 on timeout.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] data, output int lat, output bit ready_seen);
    int waitc;
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1; i_alu_op = op; i_operand_a = a; i_operand_b = b;
    waitc = 0;
    while (!o_ready && waitc < 200) begin @(negedge clk); waitc++; end
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; i_alu_op = 5'($urandom); i_operand_a = $urandom; i_operand_b = $urandom;
    lat = 0; ready_seen = 1'b0;
    while (!o_valid && lat < 100) begin
      if (o_ready) ready_seen = 1'b1;
      @(negedge clk); lat++;
    end
    if (!o_valid || waitc >= 200) lat = -1;
    data = o_alu_data;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_alu_op = '0; i_operand_a = '0; i_operand_b = '0;
    #3;
    checks++;
    if (o_valid !== 1'b0 || o_alu_data !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h ready=%b, want valid=0 data=0 ready=1", o_valid, o_alu_data, o_ready);
    end
    @(negedge clk); @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [4:0]   ops[$];
    logic [W-1:0] as[$], bs[$];
    logic [W-1:0] exp_prev;
    logic [4:0]   op;
    ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SRA};
    as  = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd4};
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'h18 + 5'($urandom_range(0, 7));
      else                           op = 5'($urandom_range(0, 15));
      ops.push_back(op); as.push_back($urandom); bs.push_back($urandom);
    end
    exp_prev = '0;
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (o_valid !== 1'b1 || o_alu_data !== exp_prev) begin
          errors++;
          $display("FAIL b2b_result[%0d] op=%h: got valid=%b data=%h, want valid=1 data=%h", i-1, ops[i-1], o_valid, o_alu_data, exp_prev);
        end
      end
      if (i == ops.size()) break;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, o_ready);
      end
      i_ready = 1'b1; i_valid = 1'b1; i_alu_op = ops[i]; i_operand_a = as[i]; i_operand_b = bs[i];
      exp_prev = model(ops[i], as[i], bs[i]);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_mul_div;
    logic [4:0]   ops[$];
    logic [W-1:0] as[$], bs[$];
    logic [W-1:0] data, exp;
    int lat;
    bit rs;
    ops = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'sd7, -32'sd7, 32'd7, 32'd7};
    bs  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    for (int i = 0; i < 24; i++) begin
      ops.push_back(5'h10 + 5'($urandom_range(0, 7)));
      as.push_back($urandom);
      case ($urandom_range(0, 3))
        0: bs.push_back($urandom_range(1, 300));
        1: bs.push_back(32'hFFFF_FFFF);
        default: bs.push_back($urandom);
      endcase
    end
    for (int i = 0; i < ops.size(); i++) begin
      run_op(ops[i], as[i], bs[i], data, lat, rs);
      exp = model(ops[i], as[i], bs[i]);
      checks++;
      if (data !== exp) begin
        errors++;
        $display("FAIL mop_result op=%h a=%h b=%h: got %h want %h", ops[i], as[i], bs[i], data, exp);
      end
      checks++;
      if (lat != exp_lat(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL mop_latency op=%h: got %0d want %0d", ops[i], lat, exp_lat(ops[i], as[i], bs[i]));
      end
      if (exp_lat(ops[i], as[i], bs[i]) > 0) begin
        checks++;
        if (rs) begin
          errors++;
          $display("FAIL mop_busy_ready op=%h: got o_ready=1 while busy, want 0", ops[i]);
        end
      end
    end
  endtask

  task automatic test_div_corners;
    logic [4:0]   ops[$];
    logic [W-1:0] as[$], bs[$];
    logic [W-1:0] data, exp;
    int lat;
    bit rs;
    ops = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    as  = '{32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF3, 32'hFFFF_FFF3};
    bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < ops.size(); i++) begin
      run_op(ops[i], as[i], bs[i], data, lat, rs);
      exp = model(ops[i], as[i], bs[i]);
      checks++;
      if (data !== exp || lat != 0) begin
        errors++;
        $display("FAIL div_corner op=%h a=%h b=%h: got %h lat=%0d want %h lat=0", ops[i], as[i], bs[i], data, lat, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a0, b0, a1, b1, exp0, exp1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    exp0 = model(OP_ADD, a0, b0); exp1 = model(OP_SUB, a1, b1);
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; i_alu_op = OP_ADD; i_operand_a = a0; i_operand_b = b0;
    @(posedge clk);
    @(negedge clk);
    i_alu_op = OP_SUB; i_operand_a = a1; i_operand_b = b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_alu_data !== exp0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h, want valid=1 data=%h", k, o_valid, o_alu_data, exp0);
      end
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low[%0d]: got %b want 0", k, o_ready);
      end
      if (k < 4) @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_release: got %b want 1", o_ready);
    end
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_alu_data !== exp1) begin
      errors++;
      $display("FAIL bp_held_accept: got valid=%b data=%h, want valid=1 data=%h", o_valid, o_alu_data, exp1);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [W-1:0] data, a, b;
    int lat;
    bit rs, seen;
    run_op(OP_ADD, 32'h1234_0000, 32'h0000_5678, data, lat, rs);
    @(negedge clk);
    i_valid = 1'b1; i_alu_op = OP_MULHU; i_operand_a = $urandom; i_operand_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_alu_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_mul: got valid=%b data=%h, want valid=0 data=0", o_valid, o_alu_data);
    end
    @(negedge clk);
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_discard: got a result after reset, want none");
    end
    a = $urandom; b = $urandom;
    run_op(OP_MULH, a, b, data, lat, rs);
    checks++;
    if (data !== model(OP_MULH, a, b) || lat != W + 1) begin
      errors++;
      $display("FAIL post_reset_mul: got %h lat=%0d want %h lat=%0d", data, lat, model(OP_MULH, a, b), W + 1);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_mul_div;
    test_div_corners;
    test_backpressure;
    test_reset_mid_mul;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the single-cycle datapath ALU.
- Adds valid/ready handshakes, a registered result, and iterative RV32M multiply/divide.
- Sits in the EX stage of the multicycle/pipelined core. A busy unit stalls issue through o_ready.
- Base ops take one cycle; M-extension ops run on a shared shift/add-subtract engine.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 8
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from i_operand_b

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  unit can accept a request this cycle
- i_alu_op  input  5  operation code (see Behaviour)
- i_operand_a  input  WIDTH  first operand
- i_operand_b  input  WIDTH  second operand
- o_valid  output  1  o_alu_data holds a result
- i_ready  input  1  consumer accepts the result
- o_alu_data  output  WIDTH  registered result

Behaviour:
- Reset (async, active-high): state=IDLE, o_valid=0, o_alu_data=0, counter=0, internal operand/accumulator registers=0.
- An in-flight operation is discarded on reset; no result is produced afterwards.
- Op codes 0x00-0x0A, base ops:
  - ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, LUI (result = b), in that order.
  - Shifts use i_operand_b[SHAMT_W-1:0].
  - SLT is signed; SLTU is unsigned; result is zero-extended 0/1.
- Op codes 0x10-0x17, M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RISC-V semantics at WIDTH).
- All other codes: result 0, single-cycle path.
- Accept condition: i_valid && o_ready. Operands and op are latched on the accept edge; later input changes are ignored.
- o_ready = (state==IDLE) && (!o_valid || i_ready). This allows back-to-back single-cycle ops at full throughput.
- Base op accepted at edge N: o_valid=1 and o_alu_data valid after edge N.
- Result hold: o_valid, o_alu_data stay stable until an edge with i_ready=1. o_valid then drops unless a new result loads on the same edge.
- States:
  - IDLE: accept. Base/illegal op -> result, stay IDLE. MUL* -> MUL. DIV* -> DIV, or IDLE on the fast path.
  - MUL: radix-2 shift-add on 2*WIDTH-bit accumulator with magnitude operands. Counter WIDTH-1..0. Takes exactly WIDTH cycles. Last cycle applies sign correction and goes to DONE.
  - DIV: restoring divide on magnitudes. Takes WIDTH cycles, then sign fix to DONE.
  - DONE: load o_alu_data, o_valid=1 -> IDLE.
- Latency: M op accepted at edge N gives o_valid after edge N+WIDTH+1.
- MULH/MULHSU/MULHU return the upper WIDTH bits; MUL returns the lower WIDTH bits.
- Divide fast path (result after edge N, 1 cycle):
  - divisor=0: DIV/DIVU quotient = all-ones, REM/REMU = dividend.
  - signed overflow (a = most-negative, b = -1): DIV = a, REM = 0.
- Signed REM takes the sign of the dividend; the quotient truncates toward zero.
- If a result is pending with i_ready=0, o_ready=0 and no new op is accepted.
- An M op can finish while o_valid is still high only if o_ready allowed the accept, so no result is ever overwritten.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: DIV/DIVU/REM/REMU execute as above.
- Undefined:
  - No divider hardware and no DIV state.
  - Codes 0x14-0x17 take the single-cycle path with result 0.
  - MUL ops are unaffected.

Test Plan:
- Base ops back-to-back, i_ready=1:
  - ADD 5+7, SUB 5-7, SLT -1<1, SLTU -1<1, SRA 0x80000000>>4 on consecutive cycles
  - -> results 12, 0xFFFFFFFE, 1, 0, 0xF8000000 on consecutive cycles, o_ready never low.
- MUL/MULH/MULHU, a=0xFFFFFFFF, b=2:
  - MUL=0xFFFFFFFE, MULH=0xFFFFFFFF, MULHU=0x00000001.
  - o_valid exactly 33 cycles after accept; o_ready=0 throughout.
- DIV/REM with a=-7, b=2:
  - DIV=-3 (0xFFFFFFFD), REM=-1; DIVU 7/2=3, REMU=1, each at 33-cycle latency.
- Corner cases, 1-cycle latency:
  - DIVU 9/0=0xFFFFFFFF, REMU 9/0=9.
  - DIV 0x80000000/-1=0x80000000, REM=0.
- Backpressure:
  - Hold i_ready=0 for 5 cycles after an ADD result: o_alu_data/o_valid stable, o_ready=0, a held i_valid is not accepted.
  - Release: the held request is accepted the same edge the result is consumed.
- Reset mid-MUL at cycle 10: o_valid=0, o_alu_data=0 immediately. Next op after reset completes normally.
